// File: rtl/comb_always_pkg.sv
// Shared definitions for the two-requester combine arbiter.
//   op_e        : op codes understood by the shared combine unit
//   out_state_e : occupancy of the single-entry output register
//   REQ_COUNT   : number of requesters sharing the datapath
//   ID_W        : width of the requester id tag
package comb_always_pkg;

    localparam int REQ_COUNT = 2;
    localparam int ID_W      = $clog2(REQ_COUNT);

    typedef enum logic [1:0] {
        PASS_A = 2'd0,
        PASS_B = 2'd1,
        OR     = 2'd2,
        RSVD   = 2'd3
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/comb_always_combine.sv
// Shared combine unit, purely combinational.
//   a, b   : WIDTH-bit operands
//   op     : op code (PASS_A, PASS_B, OR, reserved)
//   result : combined value, WIDTH bits, zero for the reserved code
//   is_bad : high when op is the reserved code
module comb_always_combine
    import comb_always_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             is_bad
);

    // Select the combine function for the presented op code.
    always_comb begin
        result = {WIDTH{1'b0}};
        is_bad = 1'b0;
        case (op_e'(op))
            PASS_A:  result = a;
            PASS_B:  result = b;
            OR:      result = a | b;
            RSVD: begin
                result = {WIDTH{1'b0}};
                is_bad = 1'b1;
            end
            default: begin
                result = {WIDTH{1'b0}};
                is_bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/comb_always_arbiter.sv
// Round-robin arbiter sharing one combine unit between two requesters,
// with a single-entry back-pressured output register tagged by requester id.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready         : requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op  : requester N operands and op code
//   out_valid/out_ready      : output register handshake
//   out_data, out_id, out_op : registered result, producing requester, op code
//   bad_op                   : sticky, set when a reserved op code is accepted
module comb_always_arbiter
    import comb_always_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [1:0]        req1_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ID_W-1:0]   out_id,
    output logic [1:0]        out_op,
    output logic              bad_op
);

    out_state_e        r_state;
    out_state_e        w_state_nxt;
    logic              r_last_grant;
    logic [WIDTH-1:0]  r_data;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_op;
    logic              r_bad;

    logic              w_accept;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_hs;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [1:0]        w_op;
    logic [WIDTH-1:0]  w_result;
    logic              w_is_bad;

    // Round-robin grant: a lone requester wins; on contention the one not
    // granted last wins (r_last_grant resets to 1 so requester 0 goes first).
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last_grant);
        w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    end

    // Grant mux feeding the single shared combine unit.
    always_comb begin
        if (w_grant1) begin
            w_a  = req1_a;
            w_b  = req1_b;
            w_op = req1_op;
        end else begin
            w_a  = req0_a;
            w_b  = req0_b;
            w_op = req0_op;
        end
    end

    comb_always_combine #(
        .WIDTH (WIDTH)
    ) u_combine (
        .a      (w_a),
        .b      (w_b),
        .op     (w_op),
        .result (w_result),
        .is_bad (w_is_bad)
    );

    // Output-stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output-stage next state: a drain with a simultaneous accept stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_hs) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_hs) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output-stage decode: acceptance window and readies. out_ready reaches
    // the readies combinationally; rst masks them so no handshake completes.
    always_comb begin
        w_accept = (r_state == ST_EMPTY) || out_ready;
        w_rdy0   = w_accept && w_grant0 && !rst;
        w_rdy1   = w_accept && w_grant1 && !rst;
        w_hs     = w_rdy0 || w_rdy1;
    end

    // Result register, round-robin history and sticky reserved-op flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= {WIDTH{1'b0}};
            r_id         <= {ID_W{1'b0}};
            r_op         <= 2'd0;
            r_bad        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_data       <= w_result;
            r_id         <= w_grant1;
            r_op         <= w_op;
            r_bad        <= r_bad | w_is_bad;
            r_last_grant <= w_grant1;
        end else begin
            r_data       <= r_data;
            r_id         <= r_id;
            r_op         <= r_op;
            r_bad        <= r_bad;
            r_last_grant <= r_last_grant;
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign out_valid  = (r_state == ST_FULL);
    assign out_data   = r_data;
    assign out_id     = r_id;
    assign out_op     = r_op;
    assign bad_op     = r_bad;

endmodule

// File: tb/tb_comb_always_arbiter.sv
// Self-checking bench for comb_always_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_comb_always_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [1:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [1:0] req1_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [0:0] out_id;
    logic [1:0] out_op;
    logic       bad_op;

    int n_checks;
    int n_fail;

    // reference model state
    int m_valid, m_data, m_id, m_op, m_bad, m_last;
    int last_e0, last_e1;
    int obs_r0, obs_r1;

    comb_always_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_op     (out_op),
        .bad_op     (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_combine(input int a, input int b, input int op);
        if (op == 0) return a;
        else if (op == 1) return b;
        else if (op == 2) return a | b;
        else return 0;
    endfunction

    // One clock cycle: check readies against the model, clock, update the
    // model, then check the registered outputs on the falling edge.
    task automatic tick();
        int acc, win, e0, e1, a, b, op;
        #1;
        acc = (m_valid == 0 || out_ready) ? 1 : 0;
        win = -1;
        if (req0_valid && req1_valid) win = 1 - m_last;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
        e0 = (!rst && acc != 0 && win == 0) ? 1 : 0;
        e1 = (!rst && acc != 0 && win == 1) ? 1 : 0;
        obs_r0 = int'(req0_ready);
        obs_r1 = int'(req1_ready);
        check_eq("req0_ready", obs_r0, e0);
        check_eq("req1_ready", obs_r1, e1);
        a  = (win == 1) ? int'(req1_a)  : int'(req0_a);
        b  = (win == 1) ? int'(req1_b)  : int'(req0_b);
        op = (win == 1) ? int'(req1_op) : int'(req0_op);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_op = 0; m_bad = 0; m_last = 1;
        end else if (e0 != 0 || e1 != 0) begin
            m_valid = 1;
            m_data  = model_combine(a, b, op);
            m_id    = win;
            m_op    = op;
            if (op == 3) m_bad = 1;
            m_last  = win;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
        last_e0 = e0;
        last_e1 = e1;
        @(negedge clk);
        check_eq("out_valid", int'(out_valid), m_valid);
        check_eq("out_data",  int'(out_data),  m_data);
        check_eq("out_id",    int'(out_id),    m_id);
        check_eq("out_op",    int'(out_op),    m_op);
        check_eq("bad_op",    int'(bad_op),    m_bad);
    endtask

    task automatic set_req0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    int exp_id[4]   = '{0, 1, 0, 1};
    int exp_data[4] = '{5, 10, 5, 10};

    initial begin
        n_checks = 0; n_fail = 0;
        m_valid = 0; m_data = 0; m_id = 0; m_op = 0; m_bad = 0; m_last = 1;
        last_e0 = 0; last_e1 = 0;
        rst = 1'b1; out_ready = 1'b0;
        set_req0(1'b0, 4'h0, 4'h0, 2'd0);
        set_req1(1'b0, 4'h0, 4'h0, 2'd0);

        // reset, then idle
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // fairness: both continuously valid
        out_ready = 1'b1;
        set_req0(1'b1, 4'h5, 4'h0, 2'd0);
        set_req1(1'b1, 4'h0, 4'hA, 2'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("fair_id",   int'(out_id),   exp_id[i]);
            check_eq("fair_data", int'(out_data), exp_data[i]);
        end

        // req0 alone, OR
        set_req1(1'b0, 4'h0, 4'h0, 2'd0);
        set_req0(1'b1, 4'h3, 4'hC, 2'd2);
        tick();
        check_eq("or_ready", obs_r0, 1);
        check_eq("or_data",  int'(out_data), 15);
        check_eq("or_op",    int'(out_op),   2);

        // back-pressure
        set_req0(1'b1, 4'h5, 4'h0, 2'd0);
        tick();
        out_ready = 1'b0;
        set_req1(1'b1, 4'h9, 4'h6, 2'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_data",  int'(out_data), 5);
            check_eq("bp_ready", obs_r0 + obs_r1, 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("b2b_ready", obs_r0 + obs_r1, 1);

        // reserved op from req1
        set_req0(1'b0, 4'h0, 4'h0, 2'd0);
        set_req1(1'b1, 4'hF, 4'h0, 2'd3);
        tick();
        check_eq("rsvd_data", int'(out_data), 0);
        check_eq("rsvd_id",   int'(out_id),   1);
        check_eq("rsvd_bad",  int'(bad_op),   1);
        set_req1(1'b0, 4'h0, 4'h0, 2'd0);
        set_req0(1'b1, 4'h3, 4'h1, 2'd1);
        tick();
        set_req0(1'b0, 4'h0, 4'h0, 2'd0);
        set_req1(1'b1, 4'h2, 4'h4, 2'd2);
        tick();
        check_eq("bad_sticky", int'(bad_op), 1);

        // reset mid-operation
        out_ready = 1'b0;
        set_req0(1'b1, 4'h7, 4'h0, 2'd0);
        set_req1(1'b1, 4'h0, 4'h8, 2'd1);
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_bad",   int'(bad_op),    0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("rst_first_grant", obs_r0, 1);

        // randomized traffic; payload held until the model sees it accepted
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid || last_e0 != 0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a  = 4'($urandom);
                req0_b  = 4'($urandom);
                req0_op = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            if (!req1_valid || last_e1 != 0) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a  = 4'($urandom);
                req1_b  = 4'($urandom);
                req1_op = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_always_arbiter.md
# comb_always_arbiter

Two-requester, round-robin controller that shares one combine datapath between two operand sources. The datapath offers pass-A, pass-B and bitwise-OR of two WIDTH-bit operands. Each requester presents an operand pair and an op code through a valid/ready handshake. The arbiter grants one requester per cycle, evaluates the shared combine unit, and registers the result into a single-entry, back-pressured output stage tagged with the requester id.

## Interface
- WIDTH, 4, operand/result width in bits

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_op  input  2  requester 0 op code (0 PASS_A, 1 PASS_B, 2 OR, 3 reserved)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  WIDTH  registered result
- out_id  output  1  requester that produced out_data
- out_op  output  2  op code that produced out_data
- bad_op  output  1  sticky flag: a reserved op code was accepted

## Operation
- Acceptance window: `accept = !out_valid || out_ready`. The output register is empty or is being drained this cycle.
- Grant:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins (round-robin).
  - `last_grant` resets to 1, so requester 0 has priority first.
- `reqN_ready = accept && grant_N`. Ready may depend on valid. At most one ready is high per cycle.
- Requesters hold valid and payload stable until ready is seen. A request withdrawn before ready is simply not served.
- Combine unit, evaluated combinationally on the granted payload:
  - PASS_A gives a
  - PASS_B gives b
  - OR gives a | b
  - reserved gives 0 and sets bad_op
- Result width is exactly WIDTH. No extension or truncation occurs.
- On a handshake (reqN_valid && reqN_ready), at the clock edge:
  - out_data, out_id and out_op load.
  - out_valid is set.
  - last_grant becomes N.
- When out_valid && out_ready and no new accept: out_valid clears. out_data, out_id and out_op hold their last value.
- State machine on out_valid:
  - EMPTY goes to FULL on accept.
  - FULL stays FULL on a simultaneous drain and accept (back-to-back).
  - FULL goes to EMPTY on drain with no accept.
  - FULL holds when out_ready is low. Both reqN_ready are 0 while held.
- bad_op is cleared only by rst.

## Timing
- Latency: handshake in cycle N produces out_valid and result in cycle N+1.
- Throughput: one result per cycle while out_ready stays high.
- Reset values:
  - out_valid=0, out_data=0, out_id=0, out_op=0, bad_op=0
  - req0_ready=0 and req1_ready=0 while rst is high
  - last_grant=1
- Reset mid-operation: a pending result is discarded; no handshake completes in a cycle where rst is high.
- Output stability: out_data, out_id and out_op stay constant while out_valid && !out_ready.
- Fairness: with both requesters continuously valid and out_ready high, grants strictly alternate 0,1,0,1…
- No combinational path from out_ready to out_data. out_ready reaches reqN_ready combinationally.

## Structure
- Shared package `comb_always_pkg`:
  - `op_e` enum (PASS_A=0, PASS_B=1, OR=2, RSVD=3)
  - `REQ_COUNT=2` constant
- Sub-module `comb_always_combine`: purely combinational, inputs a, b, op; outputs result and is_bad. It is instantiated once and fed by the grant mux.
- Top level holds the grant logic, last_grant, the output register and bad_op.

## Test plan
- Reset, then idle with no valids: all outputs 0, both readies 0 during rst and stay 0 after.
- req0 alone: a=4'h3, b=4'hC, op=OR, out_ready=1. req0_ready high in cycle N; cycle N+1 gives out_valid=1, out_data=4'hF, out_id=0, out_op=2.
- Both valid continuously, req0 PASS_A a=4'h5, req1 PASS_B b=4'hA, out_ready=1: out_id sequence 0,1,0,1 and out_data sequence 5,A,5,A, one per cycle.
- Back-pressure: FULL with out_data=4'h5, out_ready=0 for 3 cycles. Outputs hold and both readies stay 0. When out_ready rises, a new accept happens in the same cycle (back-to-back).
- Reserved op: req1 op=3, a=4'hF. out_data=0, out_id=1, bad_op=1, and bad_op stays 1 through later valid ops until rst.
- Reset mid-operation: rst asserted while FULL with both requesters valid. Next cycle out_valid=0 and last_grant=1, so req0 is granted first after release.
